alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//   Execute-issue pipeline stage directly upstream of the core's FunctionUnit. Accepts decoded
//   RV32I OP / OP-IMM instructions, applies writeback bypass to rs1/rs2, selects operand B
//   (rs2 or sign-extended imm), maps funct3/funct7 to the 4-bit FS code, and registers
//   A/B/FS/rd through a 2-entry skid buffer with valid/ready handshakes on both sides.
// PARAMETERS
//   XLEN    32  operand width (FunctionUnit width; only 32 supported)
//   FWD_EN  1   1 = writeback bypass enabled; 0 = raw register-file values used
// PORTS
//   clk          in   1     clock, all state updates on rising edge
//   rst          in   1     synchronous, active-high reset
//   in_valid     in   1     upstream instruction valid
//   in_ready     out  1     stage can accept (registered, = !skid_valid)
//   in_opcode    in   7     0110011 = OP, 0010011 = OP-IMM
//   in_funct3    in   3     funct3 field
//   in_funct7    in   7     funct7 field (OP-IMM: imm[11:5])
//   in_rs1/rs2   in   5     source register indices
//   in_rs1_val   in   XLEN  register-file read of rs1
//   in_rs2_val   in   XLEN  register-file read of rs2
//   in_imm       in   12    I-type immediate
//   in_rd        in   5     destination index
//   fwd_valid    in   1     writeback result valid this cycle
//   fwd_rd       in   5     writeback destination
//   fwd_data     in   XLEN  writeback data
//   out_valid    out  1     A/B/FS/rd valid toward FunctionUnit
//   out_ready    in   1     downstream consumes this cycle
//   out_A/out_B  out  XLEN  operands for FunctionUnit
//   out_FS       out  4     function select
//   out_rd       out  5     destination index
//   out_illegal  out  1     entry is illegal encoding; FS forced to ADD, rd forced to 0
// BEHAVIOUR
//   Reset: out_valid=0, skid empty, in_ready=1, out_A/B=0, out_FS=0000, out_rd=0, out_illegal=0.
//   Handshake: accept = in_valid & in_ready; consume = out_valid & out_ready.
//   out_* stable while out_valid & !out_ready. Latency 1 cycle accept -> out_valid (empty stage).
//   Buffer: output reg + one skid reg. Accept while out reg free or consumed -> into out reg;
//     accept while out reg held -> into skid, in_ready drops next cycle. Consume with skid
//     full -> skid moves to out reg, in_ready rises next cycle. No bubble with ready held high.
//   Decode: FS = {funct3, alt}. alt = funct7[5] for funct3=000 on OP only (SUB), and for
//     funct3=101 (SRA/SRAI); else 0. Yields ADD 0000 SUB 0001 SLL 0010 SLT 0100 SLTU 0110
//     XOR 1000 SRL 1010 SRA 1011 OR 1100 AND 1110.
//   B select: OP -> rs2 value; OP-IMM -> sign-extended in_imm (shifts: imm[4:0] used by FU).
//   Illegal: opcode not OP/OP-IMM; OP with funct7 not 0000000/0100000, or 0100000 with
//     funct3 not 000/101; OP-IMM funct3 001 with funct7!=0, funct3 101 with funct7 not
//     0000000/0100000. Illegal entries still flow (out_illegal=1, FS=ADD, rd=0).
//   Bypass (FWD_EN=1): at accept, rsN value = fwd_data if fwd_valid & fwd_rd==rsN & rsN!=0;
//     rs==0 always reads 0 regardless of in_rsN_val or bypass. Sampled once, at accept only.
//   Simultaneous accept+consume with out reg full, skid empty: new entry goes to out reg.
//   Reset mid-operation: both entries discarded, outputs to reset values next edge.
// TESTING
//   ADD x3,x1,x2 (rs1=5, rs2=7), out_ready=1 -> next cycle out_A=5,out_B=7,FS=0000,rd=3.
//   SRAI imm=0x405, SUB funct7=0100000 f3=000, ADDI imm=0xFFF -> FS=1011, 0001; ADDI B=0xFFFFFFFF.
//   out_ready=0, push 2 instrs -> in_ready=0 after 2nd; 3rd held; release -> order 1,2,3, none lost.
//   fwd_valid=1, fwd_rd=1, fwd_data=0xDEAD with rs1=1 -> out_A=0xDEAD; same with rs1=0 -> out_A=0.
//   opcode 0110111 or SLL funct7=0100000 -> out_illegal=1, FS=0000, rd=0.
//   rst asserted with skid full -> next cycle out_valid=0, in_ready=1, no stale entry emitted.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I OP/OP-IMM, bypasses writeback into rs1/rs2, and
// hands A/B/FS/rd to the FunctionUnit through a 2-entry skid buffer.
package alu_issue_stage_pkg;
    localparam int unsigned ENTRY_XLEN = 32;
    localparam int unsigned FS_W       = 4;
    localparam int unsigned REG_W      = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [ENTRY_XLEN-1:0] a;
        logic [ENTRY_XLEN-1:0] b;
        logic [FS_W-1:0]       fs;
        logic [REG_W-1:0]      rd;
        logic                  illegal;
    } issue_entry_t;
endpackage

module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [11:0]     in_imm,
    input  logic [4:0]      in_rd,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_A,
    output logic [XLEN-1:0] out_B,
    output logic [3:0]      out_FS,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    issue_entry_t head;
    issue_entry_t skid;
    issue_entry_t new_entry;
    logic         head_valid;
    logic         skid_valid;
    logic         accept;
    logic         consume;
    logic         is_op;
    logic         is_op_imm;
    logic         alt;
    logic         illegal;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_sext;

    // x0 is hard zero; otherwise the writeback result wins over the register-file read.
    function automatic logic [XLEN-1:0] src_val(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_val,
        input logic            byp_valid,
        input logic [4:0]      byp_rd,
        input logic [XLEN-1:0] byp_data
    );
        if (idx == 5'd0) begin
            return '0;
        end
        if (FWD_EN && byp_valid && (byp_rd == idx)) begin
            return byp_data;
        end
        return rf_val;
    endfunction

    assign accept  = in_valid & in_ready;
    assign consume = head_valid & out_ready;

    // Decode, illegal detection and operand selection for the incoming instruction.
    always_comb begin
        is_op     = (in_opcode == OPC_OP);
        is_op_imm = (in_opcode == OPC_OP_IMM);
        rs1_val   = src_val(in_rs1, in_rs1_val, fwd_valid, fwd_rd, fwd_data);
        rs2_val   = src_val(in_rs2, in_rs2_val, fwd_valid, fwd_rd, fwd_data);
        imm_sext  = {{(XLEN-12){in_imm[11]}}, in_imm};

        alt = 1'b0;
        if ((in_funct3 == 3'b000 && is_op) || in_funct3 == 3'b101) begin
            alt = in_funct7[5];
        end

        illegal = 1'b0;
        if (is_op) begin
            if (in_funct7 == 7'b0100000) begin
                illegal = (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
            end else if (in_funct7 != 7'b0000000) begin
                illegal = 1'b1;
            end
        end else if (is_op_imm) begin
            if (in_funct3 == 3'b001) begin
                illegal = (in_funct7 != 7'b0000000);
            end else if (in_funct3 == 3'b101) begin
                illegal = (in_funct7 != 7'b0000000) && (in_funct7 != 7'b0100000);
            end
        end else begin
            illegal = 1'b1;
        end

        new_entry.a       = rs1_val;
        new_entry.b       = is_op ? rs2_val : imm_sext;
        new_entry.fs      = illegal ? 4'b0000 : {in_funct3, alt};
        new_entry.rd      = illegal ? 5'd0 : in_rd;
        new_entry.illegal = illegal;
    end

    // Output register plus one skid register; the skid only fills when the head is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head       <= '0;
            skid       <= '0;
        end else if (skid_valid) begin
            if (consume) begin
                head       <= skid;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!head_valid || consume) begin
                head       <= new_entry;
                head_valid <= 1'b1;
            end else begin
                skid       <= new_entry;
                skid_valid <= 1'b1;
            end
        end else if (consume) begin
            head_valid <= 1'b0;
        end
    end

    assign in_ready    = ~skid_valid;
    assign out_valid   = head_valid;
    assign out_A       = head.a;
    assign out_B       = head.b;
    assign out_FS      = head.fs;
    assign out_rd      = head.rd;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases then randomized traffic with
// random backpressure, checked against an instruction-level reference model.
module tb_alu_issue_stage;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fs;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rv1;
        logic [31:0] rv2;
        logic [11:0] imm;
        logic [4:0]  rd;
        logic        fv;
        logic [4:0]  frd;
        logic [31:0] fd;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_rs1_val = '0;
    logic [31:0] in_rs2_val = '0;
    logic [11:0] in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic        fwd_valid = 1'b0;
    logic [4:0]  fwd_rd = '0;
    logic [31:0] fwd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_A;
    logic [31:0] out_B;
    logic [3:0]  out_FS;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int   vectors = 0;
    int   miscompares = 0;
    bit   rand_ready = 1'b0;
    exp_t sb[$];

    alu_issue_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_rd(in_rd),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_A(out_A), .out_B(out_B), .out_FS(out_FS),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Instruction-level model: legality by mnemonic rules, FS = 2*funct3 + alternate bit.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        bit   legal;
        bit   alt;
        e.a = (s.rs1 == 0) ? 32'd0 : ((s.fv && s.frd == s.rs1) ? s.fd : s.rv1);
        if (s.op == OP) begin
            e.b   = (s.rs2 == 0) ? 32'd0 : ((s.fv && s.frd == s.rs2) ? s.fd : s.rv2);
            legal = (s.f7 == 7'h00) || (s.f7 == 7'h20 && (s.f3 == 3'd0 || s.f3 == 3'd5));
            alt   = (s.f7 == 7'h20);
        end else begin
            e.b = 32'($signed(s.imm));
            if (s.op == OP_IMM) begin
                legal = !(s.f3 == 3'd1 && s.f7 != 7'h00)
                     && !(s.f3 == 3'd5 && s.f7 != 7'h00 && s.f7 != 7'h20);
                alt   = (s.f3 == 3'd5 && s.f7 == 7'h20);
            end else begin
                legal = 1'b0;
                alt   = 1'b0;
            end
        end
        e.fs  = legal ? 4'(int'(s.f3) * 2 + int'(alt)) : 4'd0;
        e.rd  = legal ? s.rd : 5'd0;
        e.ill = !legal;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic issue(input stim_t s);
        int waited = 0;
        in_opcode = s.op; in_funct3 = s.f3; in_funct7 = s.f7;
        in_rs1 = s.rs1; in_rs2 = s.rs2; in_rs1_val = s.rv1; in_rs2_val = s.rv2;
        in_imm = s.imm; in_rd = s.rd;
        fwd_valid = s.fv; fwd_rd = s.frd; fwd_data = s.fd;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", waited);
        end else begin
            sb.push_back(model(s));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        fwd_valid = 1'b0;
        fwd_data  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic stim_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] rv1, input logic [31:0] rv2,
                                 input logic [11:0] imm, input logic [4:0] rd);
        stim_t s;
        s.op = op; s.f3 = f3; s.f7 = f7; s.rs1 = rs1; s.rs2 = rs2;
        s.rv1 = rv1; s.rv2 = rv2; s.imm = imm; s.rd = rd;
        s.fv = 1'b0; s.frd = 5'd0; s.fd = 32'd0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int    sel = int'($urandom_range(0, 9));
        s.f3  = 3'($urandom);
        s.rs1 = 5'($urandom_range(0, 7));
        s.rs2 = 5'($urandom_range(0, 7));
        s.rv1 = $urandom;
        s.rv2 = $urandom;
        s.rd  = 5'($urandom);
        s.fv  = 1'($urandom);
        s.frd = 5'($urandom_range(0, 7));
        s.fd  = $urandom;
        s.imm = 12'($urandom);
        if (sel == 0) begin
            s.op = (($urandom & 1) != 0) ? LUI : 7'($urandom);
            s.f7 = 7'($urandom);
        end else if (sel <= 5) begin
            s.op = OP;
            case ($urandom_range(0, 5))
                0, 1, 2: s.f7 = 7'h00;
                3, 4:    s.f7 = 7'h20;
                default: s.f7 = 7'($urandom);
            endcase
        end else begin
            s.op = OP_IMM;
            if (s.f3 == 3'd1 || s.f3 == 3'd5) begin
                case ($urandom_range(0, 3))
                    0, 1:    s.imm[11:5] = 7'h00;
                    2:       s.imm[11:5] = 7'h20;
                    default: s.imm[11:5] = 7'($urandom);
                endcase
            end
            s.f7 = s.imm[11:5];
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks hold-stability under backpressure.
    initial begin
        exp_t e;
        exp_t got;
        exp_t prev = '0;
        bit   held = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            got = '{a: out_A, b: out_B, fs: out_FS, rd: out_rd, ill: out_illegal};
            if (held) begin
                vectors++;
                if (!out_valid || got !== prev) begin
                    miscompares++;
                    $display("FAIL hold_stable: got v=%0b %h expected v=1 %h", out_valid, got, prev);
                end
            end
            if (!rst && out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: got A=%h B=%h FS=%h rd=%0d ill=%0b expected none",
                             out_A, out_B, out_FS, out_rd, out_illegal);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL transfer: got A=%h B=%h FS=%h rd=%0d ill=%0b expected A=%h B=%h FS=%h rd=%0d ill=%0b",
                                 out_A, out_B, out_FS, out_rd, out_illegal, e.a, e.b, e.fs, e.rd, e.ill);
                    end
                end
            end
            held = !rst && out_valid && !out_ready;
            prev = got;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_A", out_A, 32'd0);
        check("rst_out_FS", 32'(out_FS), 32'd0);

        // Basic ADD, one cycle latency into an empty stage.
        out_ready = 1'b1;
        issue(mk(OP, 3'd0, 7'h00, 5'd1, 5'd2, 32'd5, 32'd7, 12'd0, 5'd3));
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_A", out_A, 32'd5);
        check("add_B", out_B, 32'd7);
        check("add_FS", 32'(out_FS), 32'h0);
        check("add_rd", 32'(out_rd), 32'd3);

        issue(mk(OP_IMM, 3'd5, 7'h20, 5'd4, 5'd0, 32'd9, 32'd0, 12'h405, 5'd6));
        check("srai_FS", 32'(out_FS), 32'hB);
        issue(mk(OP, 3'd0, 7'h20, 5'd4, 5'd5, 32'd9, 32'd2, 12'd0, 5'd6));
        check("sub_FS", 32'(out_FS), 32'h1);
        issue(mk(OP_IMM, 3'd0, 7'h7F, 5'd4, 5'd0, 32'd9, 32'd0, 12'hFFF, 5'd6));
        check("addi_B", out_B, 32'hFFFF_FFFF);

        // Bypass hit, then rs1=x0 ignoring bypass.
        s = mk(OP, 3'd0, 7'h00, 5'd1, 5'd2, 32'h1111, 32'd1, 12'd0, 5'd7);
        s.fv = 1'b1; s.frd = 5'd1; s.fd = 32'hDEAD;
        issue(s);
        check("fwd_A", out_A, 32'hDEAD);
        s.rs1 = 5'd0; s.frd = 5'd0; s.rv1 = 32'h2222;
        issue(s);
        check("fwd_x0_A", out_A, 32'd0);

        issue(mk(LUI, 3'd0, 7'h00, 5'd1, 5'd2, 32'd1, 32'd2, 12'h123, 5'd9));
        check("lui_illegal", 32'(out_illegal), 32'd1);
        check("lui_rd", 32'(out_rd), 32'd0);
        issue(mk(OP, 3'd1, 7'h20, 5'd1, 5'd2, 32'd1, 32'd2, 12'd0, 5'd9));
        check("sll_alt_illegal", 32'(out_illegal), 32'd1);
        check("sll_alt_FS", 32'(out_FS), 32'd0);
        @(negedge clk);

        // Backpressure: two fill head and skid, third waits until release.
        out_ready = 1'b0;
        issue(mk(OP, 3'd4, 7'h00, 5'd1, 5'd2, 32'd1, 32'd2, 12'd0, 5'd11));
        issue(mk(OP, 3'd6, 7'h00, 5'd1, 5'd2, 32'd3, 32'd4, 12'd0, 5'd12));
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        fork
            issue(mk(OP, 3'd7, 7'h00, 5'd1, 5'd2, 32'd5, 32'd6, 12'd0, 5'd13));
            begin
                repeat (3) @(negedge clk);
                check("bp_head_held", 32'(out_rd), 32'd11);
                check("bp_queue_depth", 32'(sb.size()), 32'd2);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with the skid full discards everything.
        out_ready = 1'b0;
        issue(mk(OP, 3'd0, 7'h00, 5'd1, 5'd2, 32'd1, 32'd2, 12'd0, 5'd14));
        issue(mk(OP, 3'd0, 7'h00, 5'd1, 5'd2, 32'd1, 32'd2, 12'd0, 5'd15));
        check("rstm_in_ready_low", 32'(in_ready), 32'd0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("rstm_out_valid", 32'(out_valid), 32'd0);
        check("rstm_in_ready", 32'(in_ready), 32'd1);
        check("rstm_out_rd", 32'(out_rd), 32'd0);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rstm_no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random backpressure and idle gaps.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            issue(rand_stim());
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
